// File: rtl/timer_sched.sv
// Round-robin owner of one shared count-up timer: grants one-shot timeouts to
// N_REQ requesters, programs VALUE/CTRL, then reports expiry (done) or abort.
module timer_sched #(
    parameter int          N_REQ    = 4,
    parameter logic [31:0] TMR_BASE = 32'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [32*N_REQ-1:0] ticks_i,
    input  logic [N_REQ-1:0]    cancel_i,
    output logic [N_REQ-1:0]    ack_o,
    output logic [N_REQ-1:0]    done_o,
    output logic                busy_o,
    output logic [2:0]          cur_id_o,
    output logic [31:0]         tmr_addr_o,
    output logic [31:0]         tmr_data_o,
    output logic                tmr_we_o,
    input  logic                tmr_int_i
);
    localparam logic [31:0] OFS_CTRL   = 32'h0;
    localparam logic [31:0] OFS_VALUE  = 32'h8;
    localparam logic [31:0] CTRL_START = 32'h3;
    localparam logic [31:0] CTRL_CLEAR = 32'h4;

    typedef enum logic [2:0] {IDLE, WR_VALUE, WR_CTRL, WAIT, CLEAR, ABORT} state_t;

    state_t           r_state;
    logic [2:0]       r_ptr;
    logic [2:0]       r_id;
    logic [N_REQ-1:0] r_own;
    logic             r_cancel;
    logic [N_REQ-1:0] r_ack;
    logic [N_REQ-1:0] r_done;
    logic             r_busy;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_data;

    logic             w_found;
    logic [2:0]       w_grant_id;
    logic [2:0]       w_next_ptr;
    logic [N_REQ-1:0] w_grant_oh;
    logic [31:0]      w_ticks;
    logic             w_cancel_hit;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = 3'd0;
        w_grant_oh = '0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!w_found && req_i[j] && (j == (int'(r_ptr) + k) % N_REQ)) begin
                    w_found       = 1'b1;
                    w_grant_id    = 3'(j);
                    w_grant_oh[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_ticks = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (w_grant_oh[j]) begin
                w_ticks = ticks_i[32*j +: 32];
            end
        end
    end

    assign w_next_ptr   = (w_grant_id == 3'(N_REQ - 1)) ? 3'd0 : w_grant_id + 3'd1;
    assign w_cancel_hit = |(cancel_i & r_own);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= 3'd0;
            r_id     <= 3'd0;
            r_own    <= '0;
            r_cancel <= 1'b0;
            r_ack    <= '0;
            r_done   <= '0;
            r_busy   <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= TMR_BASE;
            r_data   <= 32'h0;
        end else begin
            // NOTE: pulse outputs default low each cycle; states below only raise them.
            r_ack  <= '0;
            r_done <= '0;
            r_we   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_id    <= w_grant_id;
                        r_own   <= w_grant_oh;
                        r_ptr   <= w_next_ptr;
                        r_ack   <= w_grant_oh;
                        r_busy  <= 1'b1;
                        r_we    <= 1'b1;
                        r_addr  <= TMR_BASE | OFS_VALUE;
                        r_data  <= w_ticks;
                        r_state <= WR_VALUE;
                    end
                end
                WR_VALUE: begin
                    if (w_cancel_hit) r_cancel <= 1'b1;
                    r_we    <= 1'b1;
                    r_addr  <= TMR_BASE | OFS_CTRL;
                    r_data  <= CTRL_START;
                    r_state <= WR_CTRL;
                end
                WR_CTRL: begin
                    if (w_cancel_hit) r_cancel <= 1'b1;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Expiry beats a simultaneous cancel so the owner still sees done.
                    if (tmr_int_i) begin
                        r_we    <= 1'b1;
                        r_addr  <= TMR_BASE | OFS_CTRL;
                        r_data  <= CTRL_CLEAR;
                        r_done  <= r_own;
                        r_state <= CLEAR;
                    end else if (w_cancel_hit || r_cancel) begin
                        r_we    <= 1'b1;
                        r_addr  <= TMR_BASE | OFS_CTRL;
                        r_data  <= CTRL_CLEAR;
                        r_state <= ABORT;
                    end
                end
                CLEAR, ABORT: begin
                    r_busy   <= 1'b0;
                    r_cancel <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack_o      = r_ack;
    assign done_o     = r_done;
    assign busy_o     = r_busy;
    assign cur_id_o   = r_id;
    assign tmr_we_o   = r_we;
    assign tmr_addr_o = r_addr;
    assign tmr_data_o = r_data;

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched with a small behavioural model of the shared
// count-up timer; cycle 0 is the IDLE cycle in which a request is first sampled.
module tb_timer_sched;
    localparam logic [31:0] BASE    = 32'h4000_1000;
    localparam logic [31:0] A_CTRL  = BASE | 32'h0;
    localparam logic [31:0] A_VALUE = BASE | 32'h8;

    logic        clk;
    logic        rst;
    logic [3:0]  req_i;
    logic [31:0] ticks [4];
    logic [127:0] ticks_i;
    logic [3:0]  cancel_i;
    logic [3:0]  ack_o;
    logic [3:0]  done_o;
    logic        busy_o;
    logic [2:0]  cur_id_o;
    logic [31:0] tmr_addr_o;
    logic [31:0] tmr_data_o;
    logic        tmr_we_o;
    logic        tmr_int_i;

    int total = 0;
    int bad   = 0;

    assign ticks_i = {ticks[3], ticks[2], ticks[1], ticks[0]};

    timer_sched #(.N_REQ(4), .TMR_BASE(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .ticks_i    (ticks_i),
        .cancel_i   (cancel_i),
        .ack_o      (ack_o),
        .done_o     (done_o),
        .busy_o     (busy_o),
        .cur_id_o   (cur_id_o),
        .tmr_addr_o (tmr_addr_o),
        .tmr_data_o (tmr_data_o),
        .tmr_we_o   (tmr_we_o),
        .tmr_int_i  (tmr_int_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timer model: CTRL write restarts the count; pending sets when COUNT reaches VALUE.
    logic        t_en, t_ie, t_pend;
    logic [31:0] t_count, t_value;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t_en <= 1'b0; t_ie <= 1'b0; t_pend <= 1'b0;
            t_count <= '0; t_value <= '0;
        end else if (tmr_we_o && tmr_addr_o == A_CTRL) begin
            t_en    <= tmr_data_o[0];
            t_ie    <= tmr_data_o[1];
            t_count <= '0;
            if (tmr_data_o[2]) t_pend <= 1'b0;
        end else begin
            if (tmr_we_o && tmr_addr_o == A_VALUE) t_value <= tmr_data_o;
            if (t_en) begin
                t_count <= t_count + 32'd1;
                if (t_count == t_value) begin
                    t_pend <= 1'b1;
                    t_en   <= 1'b0;
                end
            end
        end
    end
    assign tmr_int_i = t_pend & t_ie;

    initial begin
        #500000;
        $display("FAIL watchdog: run still active at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        oh_idx = -1;
        if ($countones(v) == 1)
            for (int i = 0; i < 4; i++) if (v[i]) oh_idx = i;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy_o !== 1'b0 && n < 300) begin
            step();
            n++;
        end
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL wait_idle: busy_o=%b after %0d cycles, required 0", busy_o, n);
        end
    endtask

    task automatic test_reset();
        total++;
        if (ack_o !== 4'b0 || done_o !== 4'b0) begin
            bad++; $display("FAIL reset_pulses: ack=%b done=%b, required 0000/0000", ack_o, done_o);
        end
        total++;
        if (busy_o !== 1'b0 || cur_id_o !== 3'd0) begin
            bad++; $display("FAIL reset_busy: busy=%b cur_id=%0d, required 0/0", busy_o, cur_id_o);
        end
        total++;
        if (tmr_we_o !== 1'b0 || tmr_addr_o !== BASE || tmr_data_o !== 32'h0) begin
            bad++; $display("FAIL reset_bus: we=%b addr=%h data=%h, required 0/%h/0", tmr_we_o, tmr_addr_o, tmr_data_o, BASE);
        end
    endtask

    task automatic test_round_robin();
        int exp_id [5] = '{0, 1, 2, 3, 0};
        int ack_id [5];
        int ack_c  [5];
        int done_id[5];
        int done_c [5];
        int na = 0;
        int nd = 0;
        int c  = 0;
        for (int i = 0; i < 5; i++) begin
            ack_id[i] = -1; ack_c[i] = -1; done_id[i] = -1; done_c[i] = -1;
        end
        for (int i = 0; i < 4; i++) ticks[i] = 32'd2;
        req_i = 4'b1111;
        while (nd < 5 && c < 80) begin
            step();
            c++;
            if (ack_o !== 4'b0 && na < 5) begin
                ack_id[na] = oh_idx(ack_o); ack_c[na] = c; na++;
                if (na == 5) req_i = 4'b0;
            end
            if (done_o !== 4'b0 && nd < 5) begin
                done_id[nd] = oh_idx(done_o); done_c[nd] = c; nd++;
            end
        end
        req_i = 4'b0;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (ack_id[k] !== exp_id[k] || ack_c[k] !== 1 + 8*k) begin
                bad++; $display("FAIL rr_grant%0d: id=%0d cycle=%0d, required id=%0d cycle=%0d", k, ack_id[k], ack_c[k], exp_id[k], 1 + 8*k);
            end
            total++;
            if (done_id[k] !== exp_id[k] || done_c[k] !== 7 + 8*k) begin
                bad++; $display("FAIL rr_done%0d: id=%0d cycle=%0d, required id=%0d cycle=%0d", k, done_id[k], done_c[k], exp_id[k], 7 + 8*k);
            end
        end
        wait_idle();
    endtask

    task automatic test_single();
        int c;
        ticks[0] = 32'd10;
        req_i = 4'b0001;
        step();
        total++;
        if (ack_o !== 4'b0001 || busy_o !== 1'b1 || cur_id_o !== 3'd0) begin
            bad++; $display("FAIL single_ack: ack=%b busy=%b id=%0d, required 0001/1/0", ack_o, busy_o, cur_id_o);
        end
        total++;
        if (tmr_we_o !== 1'b1 || tmr_addr_o !== A_VALUE || tmr_data_o !== 32'd10) begin
            bad++; $display("FAIL single_value: we=%b addr=%h data=%h, required 1/%h/a", tmr_we_o, tmr_addr_o, tmr_data_o, A_VALUE);
        end
        req_i = 4'b0;
        step();
        total++;
        if (tmr_we_o !== 1'b1 || tmr_addr_o !== A_CTRL || tmr_data_o !== 32'h3 || ack_o !== 4'b0) begin
            bad++; $display("FAIL single_ctrl: we=%b addr=%h data=%h ack=%b, required 1/%h/3/0000", tmr_we_o, tmr_addr_o, tmr_data_o, ack_o, A_CTRL);
        end
        c = 2;
        do begin step(); c++; end while (done_o === 4'b0 && c < 200);
        total++;
        if (c !== 15 || done_o !== 4'b0001) begin
            bad++; $display("FAIL single_done: cycle=%0d done=%b, required 15/0001", c, done_o);
        end
        total++;
        if (tmr_we_o !== 1'b1 || tmr_addr_o !== A_CTRL || tmr_data_o !== 32'h4) begin
            bad++; $display("FAIL single_clear: we=%b addr=%h data=%h, required 1/%h/4", tmr_we_o, tmr_addr_o, tmr_data_o, A_CTRL);
        end
        step();
        total++;
        if (busy_o !== 1'b0 || tmr_we_o !== 1'b0) begin
            bad++; $display("FAIL single_idle: busy=%b we=%b at cycle 16, required 0/0", busy_o, tmr_we_o);
        end
    endtask

    task automatic test_fairness();
        int c = 1;
        ticks[2] = 32'd1;
        req_i = 4'b0100;
        step();
        total++;
        if (ack_o !== 4'b0100) begin
            bad++; $display("FAIL fair_first: ack=%b, required 0100", ack_o);
        end
        req_i = 4'b0;
        wait_idle();
        ticks[1] = 32'd1;
        ticks[3] = 32'd1;
        req_i = 4'b1010;
        step();
        total++;
        if (ack_o !== 4'b1000) begin
            bad++; $display("FAIL fair_after2: ack=%b, required 1000", ack_o);
        end
        req_i = 4'b0010;
        do begin step(); c++; end while (ack_o === 4'b0 && c < 100);
        total++;
        if (ack_o !== 4'b0010 || c !== 8) begin
            bad++; $display("FAIL fair_next: ack=%b cycle=%0d, required 0010/8", ack_o, c);
        end
        req_i = 4'b0;
        wait_idle();
    endtask

    task automatic test_cancel();
        int c;
        bit seen = 0;
        ticks[1] = 32'd100;
        req_i = 4'b0010;
        step();
        req_i = 4'b0;
        total++;
        if (ack_o !== 4'b0010) begin
            bad++; $display("FAIL cancel_ack: ack=%b, required 0010", ack_o);
        end
        repeat (9) step();
        cancel_i = 4'b0001;
        step();
        cancel_i = 4'b0;
        total++;
        if (tmr_we_o !== 1'b0 || busy_o !== 1'b1) begin
            bad++; $display("FAIL cancel_nonowner: we=%b busy=%b, required 0/1", tmr_we_o, busy_o);
        end
        repeat (9) step();
        cancel_i = 4'b0010;
        step();
        cancel_i = 4'b0;
        total++;
        if (tmr_we_o !== 1'b1 || tmr_addr_o !== A_CTRL || tmr_data_o !== 32'h4 || done_o !== 4'b0) begin
            bad++; $display("FAIL cancel_abort: we=%b addr=%h data=%h done=%b, required 1/%h/4/0000", tmr_we_o, tmr_addr_o, tmr_data_o, done_o, A_CTRL);
        end
        step();
        total++;
        if (busy_o !== 1'b0) begin
            bad++; $display("FAIL cancel_busy: busy=%b, required 0", busy_o);
        end
        for (int i = 0; i < 120; i++) begin
            step();
            if (done_o !== 4'b0) seen = 1;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL cancel_nodone: done pulse seen=%0d, required 0", seen);
        end
        ticks[0] = 32'd3;
        req_i = 4'b0001;
        step();
        req_i = 4'b0;
        total++;
        if (ack_o !== 4'b0001) begin
            bad++; $display("FAIL cancel_regrant: ack=%b, required 0001", ack_o);
        end
        c = 1;
        do begin step(); c++; end while (done_o === 4'b0 && c < 100);
        total++;
        if (c !== 8 || done_o !== 4'b0001) begin
            bad++; $display("FAIL cancel_regrant_done: cycle=%0d done=%b, required 8/0001", c, done_o);
        end
        wait_idle();
    endtask

    task automatic test_early_cancel();
        ticks[2] = 32'd50;
        req_i = 4'b0100;
        step();
        req_i = 4'b0;
        step();
        cancel_i = 4'b0100;
        step();
        cancel_i = 4'b0;
        total++;
        if (tmr_we_o !== 1'b0 || busy_o !== 1'b1) begin
            bad++; $display("FAIL early_wait: we=%b busy=%b at cycle 3, required 0/1", tmr_we_o, busy_o);
        end
        step();
        total++;
        if (tmr_we_o !== 1'b1 || tmr_addr_o !== A_CTRL || tmr_data_o !== 32'h4 || done_o !== 4'b0) begin
            bad++; $display("FAIL early_abort: we=%b addr=%h data=%h done=%b at cycle 4, required 1/%h/4/0000", tmr_we_o, tmr_addr_o, tmr_data_o, done_o, A_CTRL);
        end
        step();
        total++;
        if (busy_o !== 1'b0) begin
            bad++; $display("FAIL early_busy: busy=%b at cycle 5, required 0", busy_o);
        end
    endtask

    task automatic test_collision();
        ticks[0] = 32'd5;
        req_i = 4'b0001;
        step();
        req_i = 4'b0;
        repeat (8) step();
        total++;
        if (tmr_int_i !== 1'b1) begin
            bad++; $display("FAIL collide_int: tmr_int=%b at cycle 9, required 1", tmr_int_i);
        end
        cancel_i = 4'b0001;
        step();
        cancel_i = 4'b0;
        total++;
        if (done_o !== 4'b0001 || tmr_data_o !== 32'h4 || tmr_we_o !== 1'b1) begin
            bad++; $display("FAIL collide_done: done=%b data=%h we=%b, required 0001/4/1", done_o, tmr_data_o, tmr_we_o);
        end
        step();
        total++;
        if (busy_o !== 1'b0 || tmr_we_o !== 1'b0) begin
            bad++; $display("FAIL collide_idle: busy=%b we=%b, required 0/0", busy_o, tmr_we_o);
        end
    endtask

    task automatic test_zero_ticks();
        int c = 1;
        ticks[3] = 32'd0;
        req_i = 4'b1000;
        step();
        req_i = 4'b0;
        do begin step(); c++; end while (done_o === 4'b0 && c < 100);
        total++;
        if (c !== 5 || done_o !== 4'b1000) begin
            bad++; $display("FAIL zero_done: cycle=%0d done=%b, required 5/1000", c, done_o);
        end
        wait_idle();
    endtask

    task automatic test_async_reset();
        ticks[1] = 32'd50;
        req_i = 4'b0010;
        step();
        req_i = 4'b0;
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy_o !== 1'b0 || cur_id_o !== 3'd0 || ack_o !== 4'b0 || done_o !== 4'b0) begin
            bad++; $display("FAIL areset_state: busy=%b id=%0d ack=%b done=%b, required 0/0/0000/0000", busy_o, cur_id_o, ack_o, done_o);
        end
        total++;
        if (tmr_we_o !== 1'b0 || tmr_addr_o !== BASE || tmr_data_o !== 32'h0) begin
            bad++; $display("FAIL areset_bus: we=%b addr=%h data=%h, required 0/%h/0", tmr_we_o, tmr_addr_o, tmr_data_o, BASE);
        end
        step();
        rst = 1'b0;
        ticks[1] = 32'd1;
        ticks[3] = 32'd1;
        req_i = 4'b1010;
        step();
        req_i = 4'b0;
        total++;
        if (ack_o !== 4'b0010) begin
            bad++; $display("FAIL areset_ptr: ack=%b, required 0010", ack_o);
        end
        wait_idle();
    endtask

    initial begin
        rst = 1'b1;
        req_i = 4'b0;
        cancel_i = 4'b0;
        for (int i = 0; i < 4; i++) ticks[i] = 32'd0;
        repeat (2) step();
        test_reset();
        rst = 1'b0;
        step();
        test_round_robin();
        test_single();
        test_fairness();
        test_cancel();
        test_early_cancel();
        test_collision();
        test_zero_ticks();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
